// File: rtl/divisor_restaurador_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package divisor_restaurador_pkg;

    localparam int DEFAULT_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divisor_restaurador_cla.sv
// N-bit generate/propagate adder used as the divider's trial subtractor (A + ~B + 1).
module CarryLookAheadSumadorR #(
    parameter int N = 4
) (
    input  logic [N-1:0] Operando1,
    input  logic [N-1:0] Operando2,
    input  logic         CarryIn,
    output logic [N-1:0] Resultado,
    output logic         CarryOut
);

    logic [N-1:0] w_gen;
    logic [N-1:0] w_prop;
    logic [N:0]   w_carry;

    assign w_gen  = Operando1 & Operando2;
    assign w_prop = Operando1 ^ Operando2;

    // Carry i+1 expands to G[i] | P[i]G[i-1] | ... | P[i..0]Cin after flattening.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = CarryIn;
        for (int i = 0; i < N; i++) begin
            w_carry[i+1] = w_gen[i] | (w_prop[i] & w_carry[i]);
        end
    end

    assign Resultado = w_prop ^ w_carry[N-1:0];
    assign CarryOut  = w_carry[N];

endmodule

// File: rtl/divisor_restaurador.sv
// Unsigned restoring divider: one quotient bit per clock, N cycles per division,
// with RISC-V DIVU/REMU results for a zero divisor.
module divisor_restaurador
    import divisor_restaurador_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [N-1:0] Dividendo,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Cociente,
    output logic [N-1:0] Residuo,
    output logic         Busy,
    output logic         Done
);

    localparam int             CW        = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST_ITER = CW'(N - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_divisor;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_cociente;
    logic [N-1:0]  r_residuo;

    logic [N:0]    w_shifted;
    logic [N:0]    w_neg_divisor;
    logic [N:0]    w_diff;
    logic          w_no_borrow;
    logic          w_unused_diff_msb;
    logic [N-1:0]  w_new_rem;
    logic [N-1:0]  w_new_quot;
    logic          w_last;

    // r_quot starts as the dividend; its MSB feeds the remainder while quotient bits enter at the LSB.
    assign w_shifted     = {r_rem, r_quot[N-1]};
    assign w_neg_divisor = ~{1'b0, r_divisor};

    CarryLookAheadSumadorR #(
        .N (N + 1)
    ) u_trial_sub (
        .Operando1 (w_shifted),
        .Operando2 (w_neg_divisor),
        .CarryIn   (1'b1),
        .Resultado (w_diff),
        .CarryOut  (w_no_borrow)
    );

    // A kept difference is below the divisor, so its top bit is always zero.
    assign w_unused_diff_msb = w_diff[N];
    assign w_new_rem         = w_no_borrow ? w_diff[N-1:0] : w_shifted[N-1:0];
    assign w_new_quot        = {r_quot[N-2:0], w_no_borrow};
    assign w_last            = (r_count == LAST_ITER);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of an always_comb is defaulted first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: if (Start) w_next_state = (Divisor == '0) ? DONE : CALC;
            CALC: if (w_last) w_next_state = DONE;
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot     <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_count    <= '0;
            r_cociente <= '0;
            r_residuo  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_quot    <= Dividendo;
                        r_divisor <= Divisor;
                        r_rem     <= '0;
                        r_count   <= '0;
                        if (Divisor == '0) begin
                            r_cociente <= '1;
                            r_residuo  <= Dividendo;
                        end
                    end
                end
                CALC: begin
                    r_quot  <= w_new_quot;
                    r_rem   <= w_new_rem;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_cociente <= w_new_quot;
                        r_residuo  <= w_new_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Cociente = r_cociente;
    assign Residuo  = r_residuo;
    assign Busy     = (r_state == CALC);
    assign Done     = (r_state == DONE);

endmodule

// File: tb/tb_divisor_restaurador.sv
// Self-checking bench for divisor_restaurador at N=4: directed table, multi-cycle corner sequences
// and randomized operands compared with an arithmetic reference model.
module tb_divisor_restaurador;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [N-1:0] Dividendo;
    logic [N-1:0] Divisor;
    logic [N-1:0] Cociente;
    logic [N-1:0] Residuo;
    logic         Busy;
    logic         Done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_q;
        logic [N-1:0] exp_r;
    } vec_t;

    divisor_restaurador #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Dividendo (Dividendo),
        .Divisor   (Divisor),
        .Cociente  (Cociente),
        .Residuo   (Residuo),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned / and %, with DIVU/REMU results for a zero divisor.
    function automatic logic [2*N-1:0] ref_div(input int a, input int b);
        int q;
        int r;
        if (b == 0) begin
            q = (1 << N) - 1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q[N-1:0], r[N-1:0]};
    endfunction

    // Issues Start in IDLE, then returns at the Done sample (lat = edges after acceptance).
    task automatic start_and_wait(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output int lat, output int busy_cnt);
        Dividendo = a;
        Divisor   = b;
        Start     = 1'b1;
        tick();
        Start    = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        q        = '0;
        r        = '0;
        for (int j = 0; j < 20; j++) begin
            if (lat < 0) begin
                if (Busy) busy_cnt++;
                if (Done) begin
                    lat = j;
                    q   = Cociente;
                    r   = Residuo;
                end else begin
                    tick();
                end
            end
        end
    endtask

    task automatic finish_idle(input string tag, input logic [N-1:0] exp_q, input logic [N-1:0] exp_r);
        tick();
        check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
        check({tag, "_idle_busy"}, 32'(Busy), 32'd0);
        check({tag, "_hold_q"}, 32'(Cociente), 32'(exp_q));
        check({tag, "_hold_r"}, 32'(Residuo), 32'(exp_r));
    endtask

    task automatic run_case(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] exp_q, input logic [N-1:0] exp_r);
        logic [N-1:0] q;
        logic [N-1:0] r;
        int           lat;
        int           busy_cnt;
        start_and_wait(a, b, q, r, lat, busy_cnt);
        check({tag, "_q"}, 32'(q), 32'(exp_q));
        check({tag, "_r"}, 32'(r), 32'(exp_r));
        check({tag, "_latency"}, 32'(lat), (b == '0) ? 32'd0 : 32'(N));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), (b == '0) ? 32'd0 : 32'(N));
        finish_idle(tag, exp_q, exp_r);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        vec_t         vecs[10];
        logic [N-1:0] q;
        logic [N-1:0] r;
        int           lat;
        int           busy_cnt;
        int           n;
        logic [2*N-1:0] m;

        vecs[0] = '{a: 4'd15, b: 4'd4,  exp_q: 4'd3,  exp_r: 4'd3};
        vecs[1] = '{a: 4'd8,  b: 4'd0,  exp_q: 4'd15, exp_r: 4'd8};
        vecs[2] = '{a: 4'd0,  b: 4'd5,  exp_q: 4'd0,  exp_r: 4'd0};
        vecs[3] = '{a: 4'd15, b: 4'd1,  exp_q: 4'd15, exp_r: 4'd0};
        vecs[4] = '{a: 4'd7,  b: 4'd9,  exp_q: 4'd0,  exp_r: 4'd7};
        vecs[5] = '{a: 4'd12, b: 4'd5,  exp_q: 4'd2,  exp_r: 4'd2};
        vecs[6] = '{a: 4'd15, b: 4'd15, exp_q: 4'd1,  exp_r: 4'd0};
        vecs[7] = '{a: 4'd0,  b: 4'd0,  exp_q: 4'd15, exp_r: 4'd0};
        vecs[8] = '{a: 4'd14, b: 4'd3,  exp_q: 4'd4,  exp_r: 4'd2};
        vecs[9] = '{a: 4'd1,  b: 4'd15, exp_q: 4'd0,  exp_r: 4'd1};

        rst       = 1'b1;
        Start     = 1'b0;
        Dividendo = '0;
        Divisor   = '0;
        tick();
        tick();
        check("reset_q", 32'(Cociente), 32'd0);
        check("reset_r", 32'(Residuo), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_case($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_r);
        end

        // Second Start during the second CALC cycle must be ignored.
        Dividendo = 4'd15;
        Divisor   = 4'd4;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Dividendo = 4'd9;
        Divisor   = 4'd2;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(n);
        check("busy_start_latency", 32'(n), 32'd2);
        check("busy_start_q", 32'(Cociente), 32'd3);
        check("busy_start_r", 32'(Residuo), 32'd3);
        finish_idle("busy_start", 4'd3, 4'd3);

        // Reset during the third CALC cycle aborts the division and clears the outputs.
        Dividendo = 4'd15;
        Divisor   = 4'd4;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        check("pre_reset_busy", 32'(Busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_busy", 32'(Busy), 32'd0);
        check("midreset_done", 32'(Done), 32'd0);
        check("midreset_q", 32'(Cociente), 32'd0);
        check("midreset_r", 32'(Residuo), 32'd0);
        tick();
        check("midreset_stays_idle", 32'(Busy | Done), 32'd0);
        run_case("after_reset", 4'd12, 4'd5, 4'd2, 4'd2);

        // Reset and Start on the same edge: reset wins, nothing starts.
        Dividendo = 4'd7;
        Divisor   = 4'd1;
        rst       = 1'b1;
        Start     = 1'b1;
        tick();
        rst   = 1'b0;
        Start = 1'b0;
        check("rst_start_busy", 32'(Busy), 32'd0);
        check("rst_start_done", 32'(Done), 32'd0);
        check("rst_start_q", 32'(Cociente), 32'd0);
        tick();
        check("rst_start_later", 32'(Busy | Done), 32'd0);

        // Start held during DONE must not launch a new division.
        start_and_wait(4'd6, 4'd4, q, r, lat, busy_cnt);
        check("done_start_q", 32'(q), 32'd1);
        check("done_start_r", 32'(r), 32'd2);
        Dividendo = 4'd15;
        Divisor   = 4'd1;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        check("done_start_busy", 32'(Busy), 32'd0);
        check("done_start_done", 32'(Done), 32'd0);
        tick();
        check("done_start_idle", 32'(Busy | Done), 32'd0);
        check("done_start_hold_q", 32'(Cociente), 32'd1);
        check("done_start_hold_r", 32'(Residuo), 32'd2);

        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom_range(0, (1 << N) - 1));
            b = N'($urandom_range(0, (1 << N) - 1));
            m = ref_div(int'(a), int'(b));
            run_case($sformatf("rand%0d_%0d_%0d", i, a, b), a, b, m[2*N-1:N], m[N-1:0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divisor_restaurador.md
DIVISOR_RESTAURADOR -- requirements
Module: divisor_restaurador

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1 bit: request to begin a division, sampled only in IDLE.
REQ-005 The block SHALL have port Dividendo, input, N bits: unsigned dividend, captured on the accepting edge.
REQ-006 The block SHALL have port Divisor, input, N bits: unsigned divisor, captured on the accepting edge.
REQ-007 The block SHALL have port Cociente, output, N bits: registered quotient.
REQ-008 The block SHALL have port Residuo, output, N bits: registered remainder.
REQ-009 The block SHALL have port Busy, output, 1 bit: high while in CALC.
REQ-010 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking valid Cociente/Residuo.

Function
REQ-011 The block SHALL use FSM states IDLE, CALC and DONE.
REQ-012 IDLE with Start=1 at edge k SHALL capture the operands, clear the iteration counter and partial remainder, and go to CALC; with Divisor=0 it SHALL instead go to DONE.
REQ-013 CALC SHALL run one restoring-division iteration per edge: shift {remainder, dividend} left by 1, trial-subtract the divisor at N+1 bits, keep the difference and shift in quotient bit 1 if no borrow, else restore and shift in 0.
REQ-014 After exactly N CALC iterations (edges k+1..k+N), the block SHALL register Cociente/Residuo and enter DONE, so Done is high for the cycle after edge k+N.
REQ-015 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; Start during DONE SHALL be ignored.
REQ-016 Divide-by-zero SHALL produce Cociente = all ones and Residuo = Dividendo (RISC-V DIVU/REMU semantics), with Done high the cycle after edge k.
REQ-017 Start while Busy SHALL be ignored; captured operands SHALL NOT change until the next acceptance.
REQ-018 Cociente and Residuo SHALL hold their last values through IDLE until the next Done.
REQ-019 Arithmetic SHALL be unsigned only; the trial subtraction SHALL be N+1 bits wide so the borrow is the MSB.
REQ-020 Busy SHALL be high exactly in CALC; Done SHALL be high exactly in DONE.

Reset
REQ-021 rst=1 at any edge, including mid-CALC, SHALL force IDLE, counter 0, Cociente=0, Residuo=0, Busy=0, Done=0.
REQ-022 When rst and Start are both high at the same edge, rst SHALL win and no division SHALL start.

Structure
REQ-023 A shared package SHALL define the state enum (IDLE/CALC/DONE) and the default width constant.
REQ-024 The trial subtraction SHALL be one instance of CarryLookAheadSumadorR with N=N+1, Operando2 = inverted divisor, CarryIn=1, and CarryOut=0 signalling a borrow; no other sub-module.

Verification (bench N=4)
REQ-025 Start with Dividendo=15, Divisor=4 -> Busy for 4 cycles, then Done for 1 cycle with Cociente=3, Residuo=3.
REQ-026 Dividendo=8, Divisor=0 -> Done on the cycle after acceptance with Cociente=4'b1111, Residuo=8, Busy never high.
REQ-027 Pairs 0/5, 15/1 and 7/9 -> (Cociente, Residuo) = (0,0), (15,0) and (0,7) respectively.
REQ-028 Start 15/4, then Start 9/2 at the second CALC cycle -> the second request is ignored and the result is Cociente=3, Residuo=3.
REQ-029 rst asserted at the third CALC cycle -> next cycle IDLE with all outputs 0; a new Start 12/5 then gives Cociente=2, Residuo=2.
REQ-030 Randomized 1000 operand pairs SHALL match a reference model of / and %, with Done exactly N cycles after acceptance.
